// File: rtl/neuron_bus_master.sv
// neuron_bus_master: bus initiator that loads coefficients, launches a job on the neuron slave, polls and returns the result
// Ports:
//   CLK, MasterReset_n            clock (rising edge), asynchronous active-low reset
//   coef_we/coef_idx/coef_data    shadow write (idx 0..19 coefficients, 20 offset, 21..31 ignored)
//   job_valid/job_ready/job_data  job request handshake carrying the input sample
//   res_valid/res_ready/res_data  result handshake; res_error and res_timeout qualify res_data
//   busy                          FSM is not idle
//   write/read/address/writedata  slave command outputs (registered)
//   readdata                      slave read data, sampled at the edge that ends a read cycle
module neuron_bus_master #(
    parameter int         Width       = 32,
    parameter logic [8:0] ADDR_COEF0  = 9'd0,
    parameter logic [8:0] ADDR_OFFSET = 9'd20,
    parameter logic [8:0] ADDR_INDATO = 9'd21,
    parameter logic [8:0] ADDR_START  = 9'd22,
    parameter logic [8:0] ADDR_STATUS = 9'd23,
    parameter logic [8:0] ADDR_RESULT = 9'd24,
    parameter int         TIMEOUT     = 1023
) (
    input  logic             CLK,
    input  logic             MasterReset_n,
    input  logic             coef_we,
    input  logic [4:0]       coef_idx,
    input  logic [Width-1:0] coef_data,
    input  logic             job_valid,
    output logic             job_ready,
    input  logic [Width-1:0] job_data,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [Width-1:0] res_data,
    output logic             res_error,
    output logic             res_timeout,
    output logic             busy,
    output logic             write,
    output logic             read,
    output logic [8:0]       address,
    output logic [Width-1:0] writedata,
    input  logic [Width-1:0] readdata
);
    typedef enum logic [2:0] {IDLE, LOAD, WR_IN, WR_START, POLL, RD_RES, DONE} state_t;
    localparam int TW = $clog2(TIMEOUT + 1);

    state_t           state;
    logic [Width-1:0] shadow [0:20];
    logic [Width-1:0] img [0:20];
    logic [Width-1:0] sample;
    logic [4:0]       k;
    logic [TW-1:0]    cnt;
    logic             dirty, err, armed, accept, shadow_we;

    assign shadow_we = coef_we && coef_idx <= 5'd20;
    assign job_ready = armed && state == IDLE && !coef_we && !res_valid;
    assign accept    = job_valid && job_ready;
    assign busy      = state != IDLE;

    // img is a snapshot taken at accept so shadow writes during a load only reach the next job
    always_ff @(posedge CLK or negedge MasterReset_n) begin
        if (!MasterReset_n) begin
            state       <= IDLE;
            for (int i = 0; i <= 20; i++) begin
                shadow[i] <= '0;
                img[i]    <= '0;
            end
            sample      <= '0;
            k           <= '0;
            cnt         <= '0;
            dirty       <= 1'b1;
            err         <= 1'b0;
            armed       <= 1'b0;
            write       <= 1'b0;
            read        <= 1'b0;
            address     <= '0;
            writedata   <= '0;
            res_valid   <= 1'b0;
            res_data    <= '0;
            res_error   <= 1'b0;
            res_timeout <= 1'b0;
        end else begin
            armed <= 1'b1;
            if (shadow_we) shadow[coef_idx] <= coef_data;
            dirty <= shadow_we ? 1'b1 : accept ? 1'b0 : dirty;
            case (state)
                IDLE: if (accept) begin
                    sample <= job_data;
                    err    <= 1'b0;
                    cnt    <= '0;
                    write  <= 1'b1;
                    if (dirty) begin
                        img       <= shadow;
                        k         <= '0;
                        state     <= LOAD;
                        address   <= ADDR_COEF0;
                        writedata <= shadow[0];
                    end else begin
                        state     <= WR_IN;
                        address   <= ADDR_INDATO;
                        writedata <= job_data;
                    end
                end
                LOAD: if (k == 5'd20) begin
                    state     <= WR_IN;
                    address   <= ADDR_INDATO;
                    writedata <= sample;
                end else begin
                    k         <= k + 5'd1;
                    address   <= (k == 5'd19) ? ADDR_OFFSET : ADDR_COEF0 + 9'(k) + 9'd1;
                    writedata <= img[k + 5'd1];
                end
                WR_IN: begin
                    state     <= WR_START;
                    address   <= ADDR_START;
                    writedata <= Width'(1);
                end
                WR_START: begin
                    state     <= POLL;
                    write     <= 1'b0;
                    read      <= 1'b1;
                    address   <= ADDR_STATUS;
                    writedata <= '0;
                end
                POLL: begin
                    err <= err | readdata[1];
                    cnt <= cnt + 1'b1;
                    if (readdata[0]) begin
                        state   <= RD_RES;
                        address <= ADDR_RESULT;
                    end else if (cnt == TW'(TIMEOUT - 1)) begin
                        state       <= DONE;
                        read        <= 1'b0;
                        address     <= '0;
                        res_valid   <= 1'b1;
                        res_data    <= '0;
                        res_error   <= err | readdata[1];
                        res_timeout <= 1'b1;
                    end
                end
                RD_RES: begin
                    state       <= DONE;
                    read        <= 1'b0;
                    address     <= '0;
                    res_valid   <= 1'b1;
                    res_data    <= readdata;
                    res_error   <= err;
                    res_timeout <= 1'b0;
                end
                DONE: if (res_ready) begin
                    state     <= IDLE;
                    res_valid <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_neuron_bus_master.sv
// tb_neuron_bus_master: scoreboard bench for neuron_bus_master with a behavioural slave
module tb_neuron_bus_master;
    localparam int W  = 32;
    localparam int TO = 15;

    logic         CLK = 0, MasterReset_n = 0;
    logic         coef_we = 0;
    logic [4:0]   coef_idx = 0;
    logic [W-1:0] coef_data = 0;
    logic         job_valid = 0, job_ready;
    logic [W-1:0] job_data = 0;
    logic         res_valid, res_ready = 0, res_error, res_timeout, busy;
    logic [W-1:0] res_data;
    logic         write, read;
    logic [8:0]   address;
    logic [W-1:0] writedata, readdata;

    always #5 CLK = ~CLK;

    neuron_bus_master #(.Width(W), .TIMEOUT(TO)) dut (
        .CLK(CLK), .MasterReset_n(MasterReset_n),
        .coef_we(coef_we), .coef_idx(coef_idx), .coef_data(coef_data),
        .job_valid(job_valid), .job_ready(job_ready), .job_data(job_data),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_error(res_error), .res_timeout(res_timeout), .busy(busy),
        .write(write), .read(read), .address(address),
        .writedata(writedata), .readdata(readdata)
    );

    int vectors = 0, errs = 0;
    bit mon_en = 0;
    logic [W-1:0] sh [0:20];
    bit dirty_m = 1;
    logic [42:0] exp_bus [$];
    logic [33:0] exp_res [$];
    int polls = 0, base = 0, listo_at = 0, err_at = 0;
    logic [W-1:0] cur_res = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        vectors++;
        if (got !== want) begin
            errs++;
            $display("FAIL %s: got %h, want %h at %0t", tag, got, want, $time);
        end
    endtask

    // Slave model: status reply depends on how many status polls this job has made so far
    always @(posedge CLK) if (read && address == 9'd23) polls <= polls + 1;
    always_comb begin
        readdata = '0;
        if (read && address == 9'd23)
            readdata = (polls - base + 1 == listo_at) ? W'(1) : (polls - base + 1 == err_at) ? W'(2) : '0;
        else if (read && address == 9'd24)
            readdata = cur_res;
    end

    always @(negedge CLK) if (mon_en && MasterReset_n && (write || read)) begin
        check("rw_excl", 64'(write & read), 64'd0);
        if (exp_bus.size() == 0) check("bus_extra", {21'b0, write, read, address, writedata}, 64'd0);
        else check("bus", {21'b0, write, read, address, writedata}, {21'b0, exp_bus.pop_front()});
    end

    task automatic coef_wr(input int idx, input logic [W-1:0] d);
        @(negedge CLK);
        coef_we = 1; coef_idx = 5'(idx); coef_data = d;
        if (idx <= 20) begin sh[idx] = d; dirty_m = 1; end
        @(negedge CLK);
        coef_we = 0;
    endtask

    task automatic run_job(input logic [W-1:0] d, input int la, input int ea, input logic [W-1:0] r,
                           input int exp_lat, input int hold, input bit inject);
        int npoll, lat;
        bit ok, e;
        logic [33:0] er;
        ok = la > 0 && la <= TO;
        npoll = ok ? la : TO;
        if (dirty_m) for (int i = 0; i <= 20; i++) exp_bus.push_back({2'b10, 9'(i), sh[i]});
        dirty_m = 0;
        exp_bus.push_back({2'b10, 9'd21, d});
        exp_bus.push_back({2'b10, 9'd22, W'(1)});
        for (int i = 0; i < npoll; i++) exp_bus.push_back({2'b01, 9'd23, W'(0)});
        if (ok) exp_bus.push_back({2'b01, 9'd24, W'(0)});
        e = ea > 0 && ea <= npoll;
        exp_res.push_back({ok ? r : W'(0), e, !ok});
        listo_at = la; err_at = ea; cur_res = r; base = polls;
        @(negedge CLK);
        job_valid = 1; job_data = d;
        for (lat = 0; !job_ready && lat < 100; lat++) @(negedge CLK);
        if (!job_ready) begin
            check("accept_tmo", 64'd0, 64'd1);
            job_valid = 0;
            return;
        end
        @(posedge CLK);
        #1 job_valid = 0;
        lat = 0;
        while (!res_valid && lat < 300) begin
            @(negedge CLK);
            lat++;
            if (inject && read && address == 9'd23) begin
                coef_we = 1; coef_idx = 5; coef_data = 32'hFF000000;
                sh[5] = 32'hFF000000; dirty_m = 1; inject = 0;
                @(negedge CLK);
                lat++;
                coef_we = 0;
            end
        end
        if (!res_valid) begin
            check("res_tmo", 64'd0, 64'd1);
            return;
        end
        if (exp_lat > 0) check("latency", 64'(lat), 64'(exp_lat));
        er = exp_res.pop_front();
        check("res_data", 64'(res_data), 64'(er[33:2]));
        check("res_error", 64'(res_error), 64'(er[1]));
        check("res_timeout", 64'(res_timeout), 64'(er[0]));
        repeat (hold) begin
            @(negedge CLK);
            check("hold_valid", 64'(res_valid), 64'd1);
            check("hold_out", 64'({res_data, res_error, res_timeout}), 64'(er));
            check("hold_jready", 64'(job_ready), 64'd0);
        end
        res_ready = 1;
        @(posedge CLK);
        #1 res_ready = 0;
        check("valid_drop", 64'(res_valid), 64'd0);
    endtask

    initial begin
        for (int i = 0; i <= 20; i++) sh[i] = '0;
        #12;
        check("rst_write", 64'(write), 64'd0);
        check("rst_read", 64'(read), 64'd0);
        check("rst_addr", 64'(address), 64'd0);
        check("rst_wdata", 64'(writedata), 64'd0);
        check("rst_res", 64'({res_valid, res_data, res_error, res_timeout}), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        @(negedge CLK);
        #2 MasterReset_n = 1;
        #1 check("jready_first", 64'(job_ready), 64'd0);
        @(negedge CLK);
        check("jready_idle", 64'(job_ready), 64'd1);
        mon_en = 1;

        for (int i = 0; i <= 20; i++) coef_wr(i, 32'h01000000 + W'(i));
        run_job(32'h00800000, 3, 0, 32'h00C00000, 28, 0, 0);
        run_job(32'h12345678, 1, 0, 32'h00400000, 5, 0, 0);
        run_job(32'h00100000, 3, 0, 32'h00A00000, 7, 0, 1);
        run_job(32'h00200000, 1, 0, 32'h00B00000, 26, 0, 0);
        run_job(32'h00300000, 2, 1, 32'h00110000, 6, 3, 0);
        run_job(32'h00400000, 1, 0, 32'h00220000, 5, 0, 0);
        run_job(32'h00500000, 0, 0, 32'hDEADBEEF, 18, 0, 0);

        // abort a coefficient load at k = 7 with an asynchronous reset
        coef_wr(3, 32'hAAAA5555);
        mon_en = 0;
        @(negedge CLK);
        job_valid = 1; job_data = 32'h00600000;
        for (int i = 0; !job_ready && i < 100; i++) @(negedge CLK);
        @(posedge CLK);
        #1 job_valid = 0;
        for (int i = 0; i < 50 && !(write && address == 9'd7); i++) @(negedge CLK);
        check("load_k7", 64'(address), 64'd7);
        #2 MasterReset_n = 0;
        #1 check("async_write", 64'(write), 64'd0);
        check("async_busy", 64'(busy), 64'd0);
        check("async_addr", 64'(address), 64'd0);
        for (int i = 0; i <= 20; i++) sh[i] = '0;
        dirty_m = 1;
        @(negedge CLK);
        #2 MasterReset_n = 1;
        @(negedge CLK);
        mon_en = 1;
        run_job(32'h00700000, 1, 0, 32'h00330000, 26, 10, 0);

        repeat (3) @(negedge CLK);
        check("bus_left", 64'(exp_bus.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
